// File: rtl/rx_audio_drain_pkg.sv
// -----------------------------------------------------------------------------
// rx_audio_drain_pkg
// Shared definitions for the receive-audio drain engine:
//   - state_t        : drain FSM states
//   - cap_t          : tag that says which word the buffer returns this cycle
//   - WORDS_PER_SLOT : words per channel triplet (i, q, iq3)
//   - TRAILER_WORDS  : words in the frame trailer (3 ticks words + buf_ctr)
//   - TICKS_*_WORD   : lane index of each trailer ticks word inside ticks_out
// -----------------------------------------------------------------------------
package rx_audio_drain_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        RD_Q,
        RD_IQ3,
        HOLD,
        RD_T0,
        RD_T1,
        RD_T2,
        RD_CTR,
        DONE
    } state_t;

    // The buffer answers a strobe one cycle later, so the strobe issuer
    // leaves a tag behind that tells the capture logic where the word goes.
    typedef enum logic [2:0] {
        CAP_NONE,
        CAP_I,
        CAP_Q,
        CAP_IQ3,
        CAP_T0,
        CAP_T1,
        CAP_T2,
        CAP_CTR
    } cap_t;

    localparam int WORDS_PER_SLOT = 3;
    localparam int TRAILER_WORDS  = 4;

    // Trailer order is ticks[15:0], ticks[31:16], ticks[47:32].
    localparam int TICKS_LO_WORD  = 0;
    localparam int TICKS_MID_WORD = 1;
    localparam int TICKS_HI_WORD  = 2;

endpackage

// File: rtl/rx_drain_pend.sv
// -----------------------------------------------------------------------------
// rx_drain_pend
// Saturating count of completed frames waiting to be drained.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   inc    : one frame completed by the buffer writer
//   dec    : one frame fully drained
//   count  : frames pending
//   ovf    : one-cycle pulse when an inc arrives at saturation and is dropped
// A simultaneous inc and dec cancel, even at saturation (no overflow then).
// -----------------------------------------------------------------------------
module rx_drain_pend #(
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= inc && !dec && (count == PEND_MAX);
            case ({inc, dec})
                2'b10: if (count != PEND_MAX) count <= count + 1'b1;
                2'b01: if (count != '0)       count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rx_audio_drain.sv
// -----------------------------------------------------------------------------
// rx_audio_drain
// Drains completed audio frames from the receive buffer and presents them as
// per-channel (i, q, iq3) samples on a valid/ready handshake, followed by the
// frame timestamp and frame counter.
//
// Frame layout in the buffer: nrx_samps*V_RX_CHANS triplets (channel 0 first),
// then ticks[15:0], ticks[31:16], ticks[47:32], then buf_ctr.
//
// Ports
//   cpu_clk          : clock
//   reset_C          : asynchronous active-high reset
//   buf_srq_C        : one pulse per completed frame in the buffer
//   nrx_samps[7:0]   : sample slots per frame, latched when a frame starts
//   get_rx_samp_C    : buffer read strobe (read address advances per strobe)
//   rx_dout_C[15:0]  : buffer data, valid the cycle after the strobe
//   smp_valid/ready  : sample handshake
//   smp_rxn[3:0]     : channel index of the presented sample
//   smp_i/q/iq3      : sample words, stable while smp_valid is high
//   ticks_out[47:0]  : timestamp of the last completed frame
//   buf_ctr_out[15:0]: counter of the last completed frame
//   frame_done       : one-cycle pulse per completed frame
//   seq_err          : one-cycle pulse with frame_done on a counter gap
//   pend_ovf         : one-cycle pulse when a frame notification is dropped
//
// Optional feature: define RX_DRAIN_SEQ_CHECK_EN to check that buf_ctr
// increments by one per frame. Without it seq_err is tied low.
// -----------------------------------------------------------------------------
module rx_audio_drain #(
    parameter int V_RX_CHANS = 4,
    parameter int PEND_W     = 4
) (
    input  logic        cpu_clk,
    input  logic        reset_C,
    input  logic        buf_srq_C,
    input  logic [7:0]  nrx_samps,
    output logic        get_rx_samp_C,
    input  logic [15:0] rx_dout_C,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [3:0]  smp_rxn,
    output logic [15:0] smp_i,
    output logic [15:0] smp_q,
    output logic [15:0] smp_iq3,
    output logic [47:0] ticks_out,
    output logic [15:0] buf_ctr_out,
    output logic        frame_done,
    output logic        seq_err,
    output logic        pend_ovf
);

    import rx_audio_drain_pkg::*;

    localparam logic [3:0] LAST_CHAN = 4'(V_RX_CHANS - 1);

    logic [PEND_W-1:0] pend_count;
    logic              pend_dec;

    state_t            state, state_next;
    cap_t              cap, cap_next;
    logic [7:0]        nrx_lat;
    logic [7:0]        slot;
    logic [3:0]        chan;
    logic              start;
    logic              handshake;
    logic              last_trip;
    logic [2:0][15:0]  ticks_w;

    rx_drain_pend #(
        .PEND_W (PEND_W)
    ) u_pend (
        .clk   (cpu_clk),
        .rst   (reset_C),
        .inc   (buf_srq_C),
        .dec   (pend_dec),
        .count (pend_count),
        .ovf   (pend_ovf)
    );

    assign handshake = smp_valid && smp_ready;
    assign last_trip = (chan == LAST_CHAN) && (slot == nrx_lat - 8'd1);

    // -------------------------------------------------------------------------
    // State and capture-tag registers
    // -------------------------------------------------------------------------
    always_ff @(posedge cpu_clk or posedge reset_C) begin
        if (reset_C) begin
            state <= IDLE;
            cap   <= CAP_NONE;
        end else begin
            state <= state_next;
            cap   <= cap_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, read strobe and capture tag
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_next    = state;
        cap_next      = CAP_NONE;
        get_rx_samp_C = 1'b0;
        start         = 1'b0;
        pend_dec      = 1'b0;

        case (state)
            IDLE: begin
                if (pend_count != '0) begin
                    start      = 1'b1;
                    state_next = (nrx_samps == 8'd0) ? RD_T0 : RD_I;
                end
            end
            RD_I: begin
                get_rx_samp_C = 1'b1;
                cap_next      = CAP_I;
                state_next    = RD_Q;
            end
            RD_Q: begin
                get_rx_samp_C = 1'b1;
                cap_next      = CAP_Q;
                state_next    = RD_IQ3;
            end
            RD_IQ3: begin
                get_rx_samp_C = 1'b1;
                cap_next      = CAP_IQ3;
                state_next    = HOLD;
            end
            // The first HOLD cycle waits for iq3 to land; afterwards HOLD
            // waits for the consumer.
            HOLD: begin
                if (handshake) state_next = last_trip ? RD_T0 : RD_I;
            end
            RD_T0: begin
                get_rx_samp_C = 1'b1;
                cap_next      = CAP_T0;
                state_next    = RD_T1;
            end
            RD_T1: begin
                get_rx_samp_C = 1'b1;
                cap_next      = CAP_T1;
                state_next    = RD_T2;
            end
            RD_T2: begin
                get_rx_samp_C = 1'b1;
                cap_next      = CAP_T2;
                state_next    = RD_CTR;
            end
            RD_CTR: begin
                get_rx_samp_C = 1'b1;
                cap_next      = CAP_CTR;
                state_next    = DONE;
            end
            // The first DONE cycle captures buf_ctr; the second one carries
            // the frame_done pulse and retires the frame.
            DONE: begin
                if (frame_done) begin
                    pend_dec   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Counters and capture datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge cpu_clk or posedge reset_C) begin
        if (reset_C) begin
            nrx_lat     <= '0;
            slot        <= '0;
            chan        <= '0;
            smp_valid   <= 1'b0;
            smp_rxn     <= '0;
            smp_i       <= '0;
            smp_q       <= '0;
            smp_iq3     <= '0;
            ticks_w     <= '0;
            ticks_out   <= '0;
            buf_ctr_out <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (start) begin
                nrx_lat <= nrx_samps;
                slot    <= '0;
                chan    <= '0;
            end else if (handshake) begin
                smp_valid <= 1'b0;
                if (chan == LAST_CHAN) begin
                    chan <= '0;
                    slot <= slot + 8'd1;
                end else begin
                    chan <= chan + 4'd1;
                end
            end

            case (cap)
                CAP_I:   smp_i <= rx_dout_C;
                CAP_Q:   smp_q <= rx_dout_C;
                CAP_IQ3: begin
                    smp_iq3   <= rx_dout_C;
                    smp_rxn   <= chan;
                    smp_valid <= 1'b1;
                end
                CAP_T0:  ticks_w[TICKS_LO_WORD]  <= rx_dout_C;
                CAP_T1:  ticks_w[TICKS_MID_WORD] <= rx_dout_C;
                CAP_T2:  ticks_w[TICKS_HI_WORD]  <= rx_dout_C;
                CAP_CTR: begin
                    buf_ctr_out <= rx_dout_C;
                    ticks_out   <= ticks_w;
                    frame_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame-counter sequence check
    // -------------------------------------------------------------------------
`ifdef RX_DRAIN_SEQ_CHECK_EN
    logic [15:0] exp_ctr;
    logic        seq_armed;   // low until the first frame after reset

    always_ff @(posedge cpu_clk or posedge reset_C) begin
        if (reset_C) begin
            exp_ctr   <= '0;
            seq_armed <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (cap == CAP_CTR) begin
                seq_err   <= seq_armed && (rx_dout_C != exp_ctr);
                // Reseed from what was received so one gap reports once.
                exp_ctr   <= rx_dout_C + 16'd1;
                seq_armed <= 1'b1;
            end
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_audio_drain.sv
// -----------------------------------------------------------------------------
// tb_rx_audio_drain
// Directed bench for rx_audio_drain (V_RX_CHANS=4, PEND_W=4). A behavioural
// buffer returns words one cycle after each strobe. Stimulus writes frames
// into the buffer and pushes the expected samples and frame trailers into
// queues; a monitor pops and compares whenever the DUT hands over a sample
// or pulses frame_done.
// -----------------------------------------------------------------------------
module tb_rx_audio_drain;

    localparam int CH = 4;

    logic        cpu_clk = 1'b0;
    logic        reset_C;
    logic        buf_srq_C;
    logic [7:0]  nrx_samps;
    logic        get_rx_samp_C;
    logic [15:0] rx_dout_C;
    logic        smp_valid;
    logic        smp_ready;
    logic [3:0]  smp_rxn;
    logic [15:0] smp_i, smp_q, smp_iq3;
    logic [47:0] ticks_out;
    logic [15:0] buf_ctr_out;
    logic        frame_done, seq_err, pend_ovf;

    rx_audio_drain #(.V_RX_CHANS(CH), .PEND_W(4)) dut (
        .cpu_clk       (cpu_clk),
        .reset_C       (reset_C),
        .buf_srq_C     (buf_srq_C),
        .nrx_samps     (nrx_samps),
        .get_rx_samp_C (get_rx_samp_C),
        .rx_dout_C     (rx_dout_C),
        .smp_valid     (smp_valid),
        .smp_ready     (smp_ready),
        .smp_rxn       (smp_rxn),
        .smp_i         (smp_i),
        .smp_q         (smp_q),
        .smp_iq3       (smp_iq3),
        .ticks_out     (ticks_out),
        .buf_ctr_out   (buf_ctr_out),
        .frame_done    (frame_done),
        .seq_err       (seq_err),
        .pend_ovf      (pend_ovf)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic [3:0]  rxn;
        logic [15:0] i;
        logic [15:0] q;
        logic [15:0] iq3;
    } samp_t;

    typedef struct packed {
        logic [47:0] ticks;
        logic [15:0] ctr;
        logic        seq;
    } frm_t;

    samp_t       sq[$];
    frm_t        fq[$];
    logic [15:0] mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          fid = 0;
    bit          have_prev = 0;
    logic [15:0] prev_ctr = '0;

    int compared = 0, mismatched = 0;
    int cyc = 0, strobes = 0, done_cnt = 0, done_cyc = 0;
    int valid_cyc = 0, hs_cnt = 0, seq_cnt = 0, ovf_cnt = 0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic logic [15:0] word_of(int f, int p);
        return {6'(f), 10'(p)};
    endfunction

    // Writes one frame into the buffer and queues its expected responses.
    task automatic push_frame(input int nrx, input logic [15:0] ctr, input logic [47:0] tk);
        int    p = 0;
        samp_t s;
        frm_t  fr;
        for (int sl = 0; sl < nrx; sl++) begin
            for (int c = 0; c < CH; c++) begin
                s.rxn = 4'(c);
                s.i   = word_of(fid, p);
                s.q   = word_of(fid, p + 1);
                s.iq3 = word_of(fid, p + 2);
                mem[wr_ptr]     = s.i;
                mem[wr_ptr + 1] = s.q;
                mem[wr_ptr + 2] = s.iq3;
                wr_ptr += 3;
                p      += 3;
                sq.push_back(s);
            end
        end
        mem[wr_ptr]     = tk[15:0];
        mem[wr_ptr + 1] = tk[31:16];
        mem[wr_ptr + 2] = tk[47:32];
        mem[wr_ptr + 3] = ctr;
        wr_ptr += 4;
        fr.ticks = tk;
        fr.ctr   = ctr;
`ifdef RX_DRAIN_SEQ_CHECK_EN
        fr.seq   = have_prev && (ctr != 16'(prev_ctr + 16'd1));
`else
        fr.seq   = 1'b0;
`endif
        have_prev = 1;
        prev_ctr  = ctr;
        fq.push_back(fr);
        fid++;
    endtask

    // Cycle counter
    initial forever begin
        @(posedge cpu_clk);
        cyc++;
    end

    // Behavioural buffer: strobe seen in cycle N, data driven just after
    // edge N+1 and held until the next strobe's data.
    initial begin
        bit g, rs;
        rx_dout_C = '0;
        forever begin
            @(negedge cpu_clk);
            rs = reset_C;
            g  = (get_rx_samp_C === 1'b1) && !reset_C;
            if (g) strobes++;
            @(posedge cpu_clk);
            #1;
            if (rs) begin
                rd_ptr = wr_ptr;
            end else if (g) begin
                rx_dout_C = mem[rd_ptr];
                rd_ptr++;
            end
        end
    end

    // Monitor / scoreboard
    initial forever begin
        samp_t es;
        frm_t  ef;
        @(negedge cpu_clk);
        if (!reset_C) begin
            if (smp_valid) valid_cyc++;
            if (smp_valid && smp_ready) begin
                hs_cnt++;
                check("sample_expected", 64'(sq.size() != 0), 64'd1);
                if (sq.size() != 0) begin
                    es = sq.pop_front();
                    check("smp_rxn", 64'(smp_rxn), 64'(es.rxn));
                    check("smp_i",   64'(smp_i),   64'(es.i));
                    check("smp_q",   64'(smp_q),   64'(es.q));
                    check("smp_iq3", 64'(smp_iq3), 64'(es.iq3));
                end
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("frame_expected", 64'(fq.size() != 0), 64'd1);
                if (fq.size() != 0) begin
                    ef = fq.pop_front();
                    check("ticks_out",   64'(ticks_out),   64'(ef.ticks));
                    check("buf_ctr_out", 64'(buf_ctr_out), 64'(ef.ctr));
                    check("seq_err",     64'(seq_err),     64'(ef.seq));
                end
            end
            if (seq_err) begin
                seq_cnt++;
                check("seq_err_with_done", 64'(frame_done), 64'd1);
            end
            if (pend_ovf) ovf_cnt++;
        end
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d compared", compared);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic srq();
        buf_srq_C = 1'b1;
        tick();
        buf_srq_C = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(done_cnt), 64'(target));
    endtask

    task automatic check_zero(input string tag);
        @(negedge cpu_clk);
        check({tag, "_get"},      64'(get_rx_samp_C), 64'd0);
        check({tag, "_valid"},    64'(smp_valid),     64'd0);
        check({tag, "_rxn"},      64'(smp_rxn),       64'd0);
        check({tag, "_i"},        64'(smp_i),         64'd0);
        check({tag, "_q"},        64'(smp_q),         64'd0);
        check({tag, "_iq3"},      64'(smp_iq3),       64'd0);
        check({tag, "_ticks"},    64'(ticks_out),     64'd0);
        check({tag, "_ctr"},      64'(buf_ctr_out),   64'd0);
        check({tag, "_done"},     64'(frame_done),    64'd0);
        check({tag, "_seq_err"},  64'(seq_err),       64'd0);
        check({tag, "_pend_ovf"}, 64'(pend_ovf),      64'd0);
    endtask

    task automatic do_reset();
        reset_C = 1'b1;
        sq.delete();
        fq.delete();
        have_prev = 0;
        tick();
        tick();
        reset_C = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int s0, d0, h0, v0, c0, lat_a, lat_b, fb, n, q0, o0;
        reset_C   = 1'b1;
        buf_srq_C = 1'b0;
        smp_ready = 1'b1;
        nrx_samps = 8'd2;
        tick();
        tick();
        check_zero("reset");
        tick();
        reset_C = 1'b0;
        tick();
        tick();

        // Basic frame: 2 slots x 4 channels
        s0 = strobes; h0 = hs_cnt;
        push_frame(2, 16'h0010, 48'h3333_2222_1111);
        c0 = cyc;
        srq();
        wait_done(1, 300, "done_basic");
        lat_a = done_cyc - c0;
        repeat (3) tick();
        check("strobes_basic", 64'(strobes - s0), 64'd28);
        check("samples_basic", 64'(hs_cnt - h0), 64'd8);

        // Same frame shape, 3rd sample stalled 5 cycles, nrx_samps changed mid-frame
        s0 = strobes; h0 = hs_cnt; fb = fid;
        push_frame(2, 16'h0011, 48'h6666_5555_4444);
        c0 = cyc;
        srq();
        repeat (3) tick();
        nrx_samps = 8'd7;
        n = 0;
        while (hs_cnt < h0 + 2 && n < 200) begin tick(); n++; end
        smp_ready = 1'b0;
        n = 0;
        while (smp_valid !== 1'b1 && n < 50) begin tick(); n++; end
        check("stall_valid_seen", 64'(smp_valid), 64'd1);
        q0 = strobes;
        for (int k = 0; k < 5; k++) begin
            @(negedge cpu_clk);
            check("stall_valid", 64'(smp_valid), 64'd1);
            check("stall_rxn",   64'(smp_rxn),   64'd2);
            check("stall_i",     64'(smp_i),     64'(word_of(fb, 6)));
            check("stall_q",     64'(smp_q),     64'(word_of(fb, 7)));
            check("stall_iq3",   64'(smp_iq3),   64'(word_of(fb, 8)));
            tick();
        end
        check("stall_no_strobes", 64'(strobes - q0), 64'd0);
        smp_ready = 1'b1;
        wait_done(2, 300, "done_stall");
        lat_b = done_cyc - c0;
        check("stall_delay", 64'(lat_b - lat_a), 64'd5);
        repeat (3) tick();
        check("strobes_stall", 64'(strobes - s0), 64'd28);
        nrx_samps = 8'd1;

        // Counter wrap sequence, first frame after reset unchecked
        do_reset();
        d0 = done_cnt; q0 = seq_cnt;
        push_frame(1, 16'hFFFE, 48'h0000_0000_0001);
        push_frame(1, 16'hFFFF, 48'h0000_0000_0002);
        push_frame(1, 16'h0000, 48'h0000_0000_0003);
        push_frame(1, 16'h0002, 48'h0000_0000_0004);
        repeat (4) srq();
        wait_done(d0 + 4, 400, "done_seq");
        repeat (3) tick();
`ifdef RX_DRAIN_SEQ_CHECK_EN
        check("seq_err_pulses", 64'(seq_cnt - q0), 64'd1);
`else
        check("seq_err_pulses", 64'(seq_cnt - q0), 64'd0);
`endif

        // Trailer-only frame
        nrx_samps = 8'd0;
        s0 = strobes; v0 = valid_cyc; d0 = done_cnt;
        push_frame(0, 16'h0003, 48'hCAFE_BEEF_1234);
        srq();
        wait_done(d0 + 1, 100, "done_trailer_only");
        repeat (3) tick();
        check("strobes_trailer_only", 64'(strobes - s0), 64'd4);
        check("valid_trailer_only", 64'(valid_cyc - v0), 64'd0);

        // Pending overflow: 16 back-to-back notifications, 15 frames kept
        nrx_samps = 8'd2;
        d0 = done_cnt; o0 = ovf_cnt;
        for (int f = 0; f < 15; f++) push_frame(2, 16'(16'h0004 + f), {16'hA000, 16'(f), 16'h5A5A});
        buf_srq_C = 1'b1;
        repeat (15) tick();
        check("ovf_before_16th", 64'(ovf_cnt - o0), 64'd0);
        tick();
        buf_srq_C = 1'b0;
        tick();
        tick();
        check("ovf_on_16th", 64'(ovf_cnt - o0), 64'd1);
        wait_done(d0 + 15, 1200, "done_ovf");
        repeat (100) tick();
        check("ovf_frames_exact", 64'(done_cnt - d0), 64'd15);

        // Reset after 10 strobes, then a fresh frame
        s0 = strobes;
        push_frame(2, 16'h0100, 48'h0000_0000_7777);
        srq();
        n = 0;
        while (strobes - s0 < 10 && n < 100) begin tick(); n++; end
        check("midframe_strobes", 64'(strobes - s0 >= 10), 64'd1);
        reset_C = 1'b1;
        sq.delete();
        fq.delete();
        have_prev = 0;
        d0 = done_cnt;
        tick();
        check_zero("reset_midframe");
        tick();
        reset_C = 1'b0;
        tick();
        tick();
        check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        s0 = strobes;
        push_frame(2, 16'h0200, 48'h0000_0000_8888);
        srq();
        wait_done(d0 + 1, 300, "done_after_reset");
        repeat (3) tick();
        check("strobes_after_reset", 64'(strobes - s0), 64'd28);

        check("samples_left", 64'(sq.size()), 64'd0);
        check("frames_left",  64'(fq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
